// File: rtl/m6502_bus_responder.sv
// M6502 data-bus responder: mirrored work RAM, wait states, NES open bus
// and the two-phase read-modify-write handshake.
module m6502_bus_responder #(
    parameter int          RAM_BYTES   = 2048,
    parameter logic [15:0] WINDOW_BASE = 16'h0000,
    parameter logic [15:0] WINDOW_SIZE = 16'h2000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [1:0]  req_access,
    input  logic [7:0]  req_wdata,
    input  logic        wb_valid,
    input  logic [7:0]  wb_data,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int          IW  = $clog2(RAM_BYTES);
    localparam logic [3:0]  WS  = 4'(WAIT_STATES);
    localparam bit          WS0 = (WAIT_STATES == 0);
    localparam logic [16:0] LO  = {1'b0, WINDOW_BASE};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_RMW_HOLD,
        S_RMW_WAIT,
        S_RMW_RESP
    } state_t;

    state_t        r_state;
    logic [15:0]   r_addr;
    logic [1:0]    r_access;
    logic [7:0]    r_wdata;
    logic [7:0]    r_wb;
    logic [3:0]    r_cnt;
    logic [7:0]    r_latch;
    logic          r_valid;
    logic [7:0]    r_rdata;
    logic          r_err;
    logic [7:0]    r_mem [RAM_BYTES];

    logic [16:0]   w_off;
    logic          w_mapped;
    logic [IW-1:0] w_idx;
    logic          w_we;
    logic [7:0]    w_wdat;

    // Below-base addresses borrow into bit 16, so one compare covers both ends.
    assign w_off    = {1'b0, r_addr} - LO;
    assign w_mapped = !w_off[16] && (w_off < {1'b0, WINDOW_SIZE});
    assign w_idx    = r_addr[IW-1:0];

    assign w_we = w_mapped &&
                  ((r_state == S_RESP && r_access == 2'd1) ||
                   r_state == S_RMW_RESP);
    assign w_wdat = (r_state == S_RMW_RESP) ? r_wb : r_wdata;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_idx] <= w_wdat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_addr   <= 16'h0000;
            r_access <= 2'd0;
            r_wdata  <= 8'h00;
            r_wb     <= 8'h00;
            r_cnt    <= 4'd0;
            r_latch  <= 8'h00;
            r_valid  <= 1'b0;
            r_rdata  <= 8'h00;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr   <= req_addr;
                        r_access <= req_access;
                        r_wdata  <= req_wdata;
                        r_cnt    <= WS;
                        r_state  <= WS0 ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_valid <= 1'b1;
                    if (r_access == 2'd1) begin
                        r_rdata <= r_wdata;
                        r_latch <= r_wdata;
                        r_err   <= !w_mapped;
                        r_state <= S_IDLE;
                    end else begin
                        if (w_mapped) begin
                            r_rdata <= r_mem[w_idx];
                            r_latch <= r_mem[w_idx];
                        end else begin
                            r_rdata <= r_latch;
                        end
                        r_err   <= !w_mapped || (r_access == 2'd3);
                        r_state <= (r_access == 2'd2) ? S_RMW_HOLD : S_IDLE;
                    end
                end
                S_RMW_HOLD: begin
                    if (wb_valid) begin
                        r_wb    <= wb_data;
                        r_cnt   <= WS;
                        r_state <= WS0 ? S_RMW_RESP : S_RMW_WAIT;
                    end
                end
                S_RMW_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_RMW_RESP;
                    end
                end
                S_RMW_RESP: begin
                    r_valid <= 1'b1;
                    r_rdata <= r_wb;
                    r_latch <= r_wb;
                    r_err   <= !w_mapped;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = r_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
